// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : EX-stage bypass select generation from a private history of
//             retired-from-EX instructions, load-use stall detection for a
//             configurable load latency, and MUL/DIV occupancy tracking.
//  Ports    : clock_i / reset_i        - clock, synchronous active-high reset
//             ex_*_i                   - instruction currently in EX
//             id_*_i                   - sources / MD use of instruction in ID
//             flush_i                  - ID instruction is being squashed
//             fwd_a_o / fwd_b_o        - bypass select (0 = RF, k = stage k)
//             stall_o                  - freeze PC/IF-ID, bubble into ID/EX
//             md_busy_o                - MUL/DIV unit occupied
//             stall_cnt_o / fwd_cnt_o  - statistics counters
//  Options  : `define HAZARD_STATS_EN builds the saturating statistics
//             counters; otherwise both counter outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int MD_LAT     = 4,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic              id_md_op_i,
    input  logic              flush_i,
    output logic [SEL_W-1:0]  fwd_a_o,
    output logic [SEL_W-1:0]  fwd_b_o,
    output logic              stall_o,
    output logic              md_busy_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       fwd_cnt_o
);

    localparam int              CNT_W   = $clog2(MD_LAT + 1);
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT);

    // ------------------------------------------------------------------
    // History of instructions that left EX; entry 1 is the youngest.
    // ------------------------------------------------------------------
    logic [FWD_STAGES:1] hist_wr_q;
    logic [FWD_STAGES:1] hist_ld_q;
    logic [REG_AW-1:0]   hist_rd_q [1:FWD_STAGES];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hist_wr_q <= '0;
            hist_ld_q <= '0;
            for (int k = 1; k <= FWD_STAGES; k++) begin
                hist_rd_q[k] <= '0;
            end
        end else begin
            // Writes to $0 enter as non-writing so $0 can never be bypassed.
            hist_wr_q[1] <= ex_regwrite_i & (ex_rd_i != '0);
            hist_ld_q[1] <= ex_memread_i;
            hist_rd_q[1] <= ex_rd_i;
            for (int k = 2; k <= FWD_STAGES; k++) begin
                hist_wr_q[k] <= hist_wr_q[k-1];
                hist_ld_q[k] <= hist_ld_q[k-1];
                hist_rd_q[k] <= hist_rd_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Bypass selects. Scanning oldest to youngest lets the youngest
    // matching stage overwrite older ones. Load data is only usable once
    // it has travelled at least LOAD_LAT stages past EX.
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] fwd_a_d;
    logic [SEL_W-1:0] fwd_b_d;

    always_comb begin
        fwd_a_d = '0;
        fwd_b_d = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (hist_wr_q[k] && (!hist_ld_q[k] || k >= LOAD_LAT)) begin
                if (hist_rd_q[k] == ex_rs_i) fwd_a_d = SEL_W'(k);
                if (hist_rd_q[k] == ex_rt_i) fwd_b_d = SEL_W'(k);
            end
        end
    end

    assign fwd_a_o = fwd_a_d;
    assign fwd_b_o = fwd_b_d;

    // ------------------------------------------------------------------
    // Load-use: a load in EX or in the history stages whose data is not
    // yet bypassable blocks a dependent ID instruction.
    // ------------------------------------------------------------------
    logic lu_hit_d;

    always_comb begin
        lu_hit_d = 1'b0;
        if (ex_memread_i && (ex_rd_i != '0)) begin
            lu_hit_d = (id_use_rs_i && (id_rs_i == ex_rd_i)) ||
                       (id_use_rt_i && (id_rt_i == ex_rd_i));
        end
        for (int k = 1; k < LOAD_LAT; k++) begin
            if (hist_wr_q[k] && hist_ld_q[k] &&
                ((id_use_rs_i && (id_rs_i == hist_rd_q[k])) ||
                 (id_use_rt_i && (id_rt_i == hist_rd_q[k])))) begin
                lu_hit_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // MUL/DIV occupancy. A waiting MD op is released in the unit's final
    // busy cycle (count == 1): the count reaches zero on that edge while
    // the new op is accepted and reloads it, so the unit never idles
    // between back-to-back operations.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] md_cnt_q;
    logic [CNT_W-1:0] md_cnt_d;
    logic             md_block;
    logic             stall_d;
    logic             md_start;

    assign md_block  = (md_cnt_q > CNT_W'(1));
    assign md_busy_o = (md_cnt_q != '0);

    // A squashed ID instruction neither stalls nor starts the MD unit.
    assign stall_d  = (lu_hit_d | (id_md_op_i & md_block)) & ~flush_i & ~reset_i;
    assign md_start = id_md_op_i & ~stall_d & ~flush_i;
    assign stall_o  = stall_d;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start) begin
            md_cnt_d = MD_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Statistics counters (saturating).
    // ------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall_d && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (((fwd_a_d != '0) || (fwd_b_d != '0)) && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign fwd_cnt_o   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Purpose  : Directed self-checking bench for hazard_scoreboard. Instance
//             u_dut uses default parameters; u_dut2 uses FWD_STAGES = 3,
//             LOAD_LAT = 2. Both share the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clock = 1'b0;
    logic       reset;
    logic       ex_regwrite, ex_memread;
    logic [4:0] ex_rd, ex_rs, ex_rt, id_rs, id_rt;
    logic       id_use_rs, id_use_rt, id_md_op, flush;

    logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
    logic        stall, md_busy, stall2, md_busy2;
    logic [31:0] stall_cnt, fwd_cnt, stall_cnt2, fwd_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    hazard_scoreboard u_dut (
        .clock_i(clock), .reset_i(reset),
        .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
        .ex_rd_i(ex_rd), .ex_rs_i(ex_rs), .ex_rt_i(ex_rt),
        .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
        .id_md_op_i(id_md_op), .flush_i(flush),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_o(stall), .md_busy_o(md_busy),
        .stall_cnt_o(stall_cnt), .fwd_cnt_o(fwd_cnt)
    );

    hazard_scoreboard #(.FWD_STAGES(3), .LOAD_LAT(2), .MD_LAT(4)) u_dut2 (
        .clock_i(clock), .reset_i(reset),
        .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
        .ex_rd_i(ex_rd), .ex_rs_i(ex_rs), .ex_rt_i(ex_rt),
        .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt),
        .id_md_op_i(id_md_op), .flush_i(flush),
        .fwd_a_o(fwd_a2), .fwd_b_o(fwd_b2), .stall_o(stall2), .md_busy_o(md_busy2),
        .stall_cnt_o(stall_cnt2), .fwd_cnt_o(fwd_cnt2)
    );

    // Inputs change 1 time unit after the rising edge; checks follow a
    // further 1 unit later, well away from any edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_ex(input logic wr, input logic ld, input logic [4:0] rd,
                            input logic [4:0] rs, input logic [4:0] rt);
        ex_regwrite = wr; ex_memread = ld; ex_rd = rd; ex_rs = rs; ex_rt = rt;
    endtask

    task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                            input logic urt, input logic md, input logic fl);
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_md_op = md; flush = fl;
    endtask

    task automatic idle();
        drive_ex(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        drive_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_ex(1'b1, 1'b1, 5'd5, 5'd5, 5'd5);
        drive_id(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        settle();
        n_cmp++; if (fwd_a !== 2'd0) begin n_err++; $display("FAIL reset_fwd_a got %0d want 0", fwd_a); end
        n_cmp++; if (fwd_b !== 2'd0) begin n_err++; $display("FAIL reset_fwd_b got %0d want 0", fwd_b); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %0b want 0", stall); end
        n_cmp++; if (stall2 !== 1'b0) begin n_err++; $display("FAIL reset_stall2 got %0b want 0", stall2); end
        n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL reset_md_busy got %0b want 0", md_busy); end
        n_cmp++; if (md_busy2 !== 1'b0) begin n_err++; $display("FAIL reset_md_busy2 got %0b want 0", md_busy2); end
        n_cmp++; if (stall_cnt !== 32'd0 || fwd_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stats got %0d/%0d want 0/0", stall_cnt, fwd_cnt); end
        n_cmp++; if (stall_cnt2 !== 32'd0 || fwd_cnt2 !== 32'd0) begin n_err++; $display("FAIL reset_stats2 got %0d/%0d want 0/0", stall_cnt2, fwd_cnt2); end
        reset = 1'b0;
        drain();
    endtask

    task automatic test_forwarding();
        // add $3 ; sub $4,$3,$3 ; or $0,$3,$3
        drive_ex(1'b1, 1'b0, 5'd3, 5'd1, 5'd2);
        step();
        drive_ex(1'b1, 1'b0, 5'd4, 5'd3, 5'd3);
        settle();
        n_cmp++; if (fwd_a !== 2'd1) begin n_err++; $display("FAIL fwd_stage1_a got %0d want 1", fwd_a); end
        n_cmp++; if (fwd_b !== 2'd1) begin n_err++; $display("FAIL fwd_stage1_b got %0d want 1", fwd_b); end
        step();
        drive_ex(1'b0, 1'b0, 5'd0, 5'd3, 5'd3);
        settle();
        n_cmp++; if (fwd_a !== 2'd2) begin n_err++; $display("FAIL fwd_stage2_a got %0d want 2", fwd_a); end
        n_cmp++; if (fwd_b !== 2'd2) begin n_err++; $display("FAIL fwd_stage2_b got %0d want 2", fwd_b); end
        n_cmp++; if (fwd_b2 !== 2'd2) begin n_err++; $display("FAIL fwd_stage2_b_dut2 got %0d want 2", fwd_b2); end
        drain();
        // Two writers of $3 back to back: youngest wins; rt = $0 never forwards.
        drive_ex(1'b1, 1'b0, 5'd3, 5'd0, 5'd0);
        step();
        drive_ex(1'b1, 1'b0, 5'd3, 5'd0, 5'd0);
        step();
        drive_ex(1'b0, 1'b0, 5'd0, 5'd3, 5'd0);
        settle();
        n_cmp++; if (fwd_a !== 2'd1) begin n_err++; $display("FAIL fwd_youngest got %0d want 1", fwd_a); end
        n_cmp++; if (fwd_b !== 2'd0) begin n_err++; $display("FAIL fwd_rt_zero got %0d want 0", fwd_b); end
        drain();
    endtask

    task automatic test_zero_reg();
        drive_ex(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        drive_ex(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        drive_id(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        n_cmp++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin n_err++; $display("FAIL zero_fwd got %0d/%0d want 0/0", fwd_a, fwd_b); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_stall got %0b want 0", stall); end
        drain();
    endtask

    task automatic test_load_use();
        // lw $5 in EX, ID reads $5
        drive_ex(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
        drive_id(5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu1_stall_c0 got %0b want 1", stall); end
        step();
        // bubble in EX (rs field pointing at $5), dependent still in ID
        drive_ex(1'b0, 1'b0, 5'd0, 5'd5, 5'd0);
        settle();
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu1_stall_c1 got %0b want 0", stall); end
        n_cmp++; if (fwd_a !== 2'd1) begin n_err++; $display("FAIL lu1_fwd_c1 got %0d want 1", fwd_a); end
        n_cmp++; if (stall2 !== 1'b1) begin n_err++; $display("FAIL lu2_stall_hist1 got %0b want 1", stall2); end
        step();
        drive_ex(1'b1, 1'b0, 5'd8, 5'd5, 5'd0);
        drive_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        n_cmp++; if (fwd_a !== 2'd2) begin n_err++; $display("FAIL lu1_fwd_dep got %0d want 2", fwd_a); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu1_stall_c2 got %0b want 0", stall); end
        drain();
    endtask

    task automatic test_load_lat2();
        drive_ex(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
        drive_id(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        n_cmp++; if (stall2 !== 1'b1) begin n_err++; $display("FAIL ll2_stall_c0 got %0b want 1", stall2); end
        step();
        drive_ex(1'b0, 1'b0, 5'd0, 5'd7, 5'd0);
        settle();
        n_cmp++; if (stall2 !== 1'b1) begin n_err++; $display("FAIL ll2_stall_c1 got %0b want 1", stall2); end
        n_cmp++; if (fwd_a2 !== 2'd0) begin n_err++; $display("FAIL ll2_fwd_c1 got %0d want 0", fwd_a2); end
        step();
        settle();
        n_cmp++; if (stall2 !== 1'b0) begin n_err++; $display("FAIL ll2_stall_c2 got %0b want 0", stall2); end
        n_cmp++; if (fwd_a2 !== 2'd2) begin n_err++; $display("FAIL ll2_fwd_c2 got %0d want 2", fwd_a2); end
        step();
        drive_ex(1'b1, 1'b0, 5'd9, 5'd7, 5'd0);
        drive_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        n_cmp++; if (fwd_a2 !== 2'd3) begin n_err++; $display("FAIL ll2_fwd_dep got %0d want 3", fwd_a2); end
        drain();
    endtask

    task automatic test_back_to_back_md();
        drive_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        n_cmp++; if (stall !== 1'b0 || md_busy !== 1'b0) begin n_err++; $display("FAIL md_first got stall=%0b busy=%0b want 0/0", stall, md_busy); end
        step();
        for (int i = 0; i < 3; i++) begin
            settle();
            n_cmp++; if (stall !== 1'b1 || md_busy !== 1'b1) begin n_err++; $display("FAIL md_wait%0d got stall=%0b busy=%0b want 1/1", i, stall, md_busy); end
            step();
        end
        settle();
        n_cmp++; if (stall !== 1'b0 || md_busy !== 1'b1) begin n_err++; $display("FAIL md_accept got stall=%0b busy=%0b want 0/1", stall, md_busy); end
        step();
        idle();
        settle();
        n_cmp++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL md_reload got busy=%0b want 1", md_busy); end
        step(); step(); step();
        n_cmp++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL md_last got busy=%0b want 1", md_busy); end
        step();
        n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL md_done got busy=%0b want 0", md_busy); end
        drain();
    endtask

    task automatic test_flush();
        drive_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        // MD conflict and load-use conflict together, squashed by flush
        drive_ex(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
        drive_id(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        settle();
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL flush_stall got %0b want 0", stall); end
        step();
        idle();
        step(); step();
        n_cmp++; if (md_busy !== 1'b1) begin n_err++; $display("FAIL flush_count1 got busy=%0b want 1", md_busy); end
        step();
        n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL flush_noreload got busy=%0b want 0", md_busy); end
        drain();
    endtask

    task automatic test_reset_mid();
        drive_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_ex(1'b1, 1'b0, 5'd3, 5'd0, 5'd0);
        step();
        drive_ex(1'b0, 1'b0, 5'd0, 5'd3, 5'd0);
        settle();
        n_cmp++; if (fwd_a !== 2'd1 || md_busy !== 1'b1) begin n_err++; $display("FAIL rmid_pre got fwd=%0d busy=%0b want 1/1", fwd_a, md_busy); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %0b want 0", md_busy); end
        n_cmp++; if (fwd_a !== 2'd0 || fwd_a2 !== 2'd0) begin n_err++; $display("FAIL rmid_fwd got %0d/%0d want 0/0", fwd_a, fwd_a2); end
        n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL rmid_stall_cnt got %0d want 0", stall_cnt); end
        drain();
    endtask

    task automatic test_stats();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        drive_ex(1'b1, 1'b0, 5'd3, 5'd0, 5'd0);
        step();
        // one cycle with both a stall and a double forward
        drive_ex(1'b1, 1'b1, 5'd6, 5'd3, 5'd3);
        drive_id(5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        step();
`ifdef HAZARD_STATS_EN
        n_cmp++; if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL stats_stall got %0d want 1", stall_cnt); end
        n_cmp++; if (fwd_cnt !== 32'd1) begin n_err++; $display("FAIL stats_fwd got %0d want 1", fwd_cnt); end
`else
        n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL stats_stall got %0d want 0", stall_cnt); end
        n_cmp++; if (fwd_cnt !== 32'd0) begin n_err++; $display("FAIL stats_fwd got %0d want 0", fwd_cnt); end
`endif
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle();
        #1;
        test_reset();
        test_forwarding();
        test_zero_reg();
        test_load_use();
        test_load_lat2();
        test_back_to_back_md();
        test_flush();
        test_reset_mid();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
